// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial controller wrapped around an external 4-bit adder.
// Optional signed overflow flag: define SIGNED_OVF_FLAG_EN.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
`ifdef SIGNED_OVF_FLAG_EN
  output logic                   ovf,
`endif
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic [W-1:0]    sh_a, sh_b;
  logic [IW+1:0]   base;
`ifdef SIGNED_OVF_FLAG_EN
  logic            ovf_q, ovf_d;
`endif

  assign base = {idx_q, 2'b00};
  assign sh_a = a_q >> base;
  assign sh_b = b_q >> base;

  assign result = result_q;
  assign cout   = cout_q;
`ifdef SIGNED_OVF_FLAG_EN
  assign ovf    = ovf_q;
`endif

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SIGNED_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SIGNED_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state, adder drive and handshake outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    cout_d    = cout_q;
`ifdef SIGNED_OVF_FLAG_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = op_a;
          b_d      = op_b;
          carry_d  = op_cin;
          result_d = '0;
          cout_d   = 1'b0;
`ifdef SIGNED_OVF_FLAG_EN
          ovf_d    = 1'b0;
`endif
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        add_a   = sh_a[3:0];
        add_b   = sh_b[3:0];
        add_cin = carry_q;
        result_d[base +: 4] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          cout_d  = add_cout;
`ifdef SIGNED_OVF_FLAG_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                    (add_sum[3] != a_q[W-1]);
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
